// File: rtl/rlc_coder.sv
// Run-length coder for zigzag-ordered quantized coefficient blocks.
// Emits a DC difference per block followed by {run,level} AC tokens with ZRL/EOB handling.
module rlc_coder #(
  parameter int unsigned BLOCK_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coef_valid,
  input  logic [11:0] coef_data,
  input  logic [1:0]  mode,
  input  logic        frame_last_in,
  input  logic        stall,
  output logic        coef_ready,
  output logic        DC_valid,
  output logic [15:0] af_RLC_data_DC,
  output logic        valid,
  output logic [11:0] af_RLC_data_AC,
  output logic        last
);

  localparam int unsigned IW = $clog2(BLOCK_LEN);
  localparam int unsigned ZW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_LEN - 1);
  localparam logic [ZW-1:0] RUN16 = ZW'(16);
  localparam logic [11:0] ZRL_TOK = 12'hF00;
  localparam logic [11:0] EOB_TOK = 12'h000;

  typedef enum logic [1:0] {S_DC, S_AC, S_ZRL} state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [ZW-1:0] zcnt, zcnt_d;
  logic [11:0]   held, held_d;
  logic [1:0]    mode_q, mode_d;
  logic          flast_q, flast_d;
  logic [11:0]   prev_dc [3];
  logic [11:0]   prev_d  [3];
  logic          dc_valid_d, ac_valid_d, last_d;
  logic [15:0]   dc_data_d;
  logic [11:0]   ac_data_d;
  logic          accept, is_last, blk_done;
  logic [1:0]    m;
  logic [11:0]   prev_sel;

  function automatic logic [7:0] sat8(input logic [11:0] v);
    if ($signed(v) > 12'sd127)       sat8 = 8'h7F;
    else if ($signed(v) < -12'sd128) sat8 = 8'h80;
    else                             sat8 = v[7:0];
  endfunction

  assign coef_ready = !stall && (state != S_ZRL);
  assign accept     = coef_valid && coef_ready;

  // Next-state and token generation
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    zcnt_d     = zcnt;
    held_d     = held;
    mode_d     = mode_q;
    flast_d    = flast_q;
    prev_d     = prev_dc;
    dc_valid_d = 1'b0;
    dc_data_d  = af_RLC_data_DC;
    ac_valid_d = 1'b0;
    ac_data_d  = af_RLC_data_AC;
    last_d     = 1'b0;
    blk_done   = 1'b0;
    is_last    = (idx == LAST_IDX);
    m          = (mode == 2'd3) ? 2'd0 : mode;
    case (m)
      2'd1:    prev_sel = prev_dc[1];
      2'd2:    prev_sel = prev_dc[2];
      default: prev_sel = prev_dc[0];
    endcase

    case (state)
      S_DC: begin
        if (accept) begin
          dc_valid_d = 1'b1;
          dc_data_d  = {{4{coef_data[11]}}, coef_data} - {{4{prev_sel[11]}}, prev_sel};
          case (m)
            2'd1:    prev_d[1] = coef_data;
            2'd2:    prev_d[2] = coef_data;
            default: prev_d[0] = coef_data;
          endcase
          mode_d  = m;
          flast_d = frame_last_in;
          idx_d   = IW'(1);
          zcnt_d  = '0;
          state_d = S_AC;
        end
      end
      S_AC: begin
        if (accept) begin
          idx_d = is_last ? '0 : idx + IW'(1);
          if (coef_data == 12'd0) begin
            if (is_last) begin
              ac_valid_d = 1'b1;
              ac_data_d  = EOB_TOK;
              last_d     = flast_q;
              blk_done   = 1'b1;
              zcnt_d     = '0;
              state_d    = S_DC;
            end else begin
              zcnt_d = zcnt + ZW'(1);
            end
          end else if (zcnt < RUN16) begin
            ac_valid_d = 1'b1;
            ac_data_d  = {zcnt[3:0], sat8(coef_data)};
            zcnt_d     = '0;
            if (is_last) begin
              last_d   = flast_q;
              blk_done = 1'b1;
              state_d  = S_DC;
            end
          end else begin
            // First ZRL goes out on the accepting edge; the rest drain in S_ZRL
            ac_valid_d = 1'b1;
            ac_data_d  = ZRL_TOK;
            held_d     = coef_data;
            zcnt_d     = zcnt - RUN16;
            state_d    = S_ZRL;
          end
        end
      end
      S_ZRL: begin
        if (!stall) begin
          ac_valid_d = 1'b1;
          if (zcnt >= RUN16) begin
            ac_data_d = ZRL_TOK;
            zcnt_d    = zcnt - RUN16;
          end else begin
            ac_data_d = {zcnt[3:0], sat8(held)};
            zcnt_d    = '0;
            // idx already wrapped to 0 if the held coefficient closed the block
            if (idx == '0) begin
              last_d   = flast_q;
              blk_done = 1'b1;
              state_d  = S_DC;
            end else begin
              state_d  = S_AC;
            end
          end
        end
      end
      default: state_d = S_DC;
    endcase

    if (blk_done && flast_q) begin
      prev_d[0] = '0;
      prev_d[1] = '0;
      prev_d[2] = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_DC;
      idx            <= '0;
      zcnt           <= '0;
      held           <= '0;
      mode_q         <= '0;
      flast_q        <= 1'b0;
      prev_dc        <= '{default: '0};
      DC_valid       <= 1'b0;
      af_RLC_data_DC <= '0;
      valid          <= 1'b0;
      af_RLC_data_AC <= '0;
      last           <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      zcnt           <= zcnt_d;
      held           <= held_d;
      mode_q         <= mode_d;
      flast_q        <= flast_d;
      prev_dc        <= prev_d;
      DC_valid       <= dc_valid_d;
      af_RLC_data_DC <= dc_data_d;
      valid          <= ac_valid_d;
      af_RLC_data_AC <= ac_data_d;
      last           <= last_d;
    end
  end

endmodule

// File: tb/tb_rlc_coder.sv
// Bench for rlc_coder: directed vector table, stall/reset sequences and random blocks vs a token-list model.
module tb_rlc_coder;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_valid;
  logic [11:0] coef_data;
  logic [1:0]  mode;
  logic        frame_last_in;
  logic        stall;
  logic        coef_ready;
  logic        DC_valid;
  logic [15:0] af_RLC_data_DC;
  logic        valid;
  logic [11:0] af_RLC_data_AC;
  logic        last;

  rlc_coder #(.BLOCK_LEN(N)) dut (
    .clk(clk), .rst(rst), .coef_valid(coef_valid), .coef_data(coef_data),
    .mode(mode), .frame_last_in(frame_last_in), .stall(stall),
    .coef_ready(coef_ready), .DC_valid(DC_valid), .af_RLC_data_DC(af_RLC_data_DC),
    .valid(valid), .af_RLC_data_AC(af_RLC_data_AC), .last(last)
  );

  always #5 clk = ~clk;

  // Token encoding: {is_dc, last, data[15:0]}
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  logic signed [11:0] blk [N];
  int m_prev [3];
  int n_tests = 0;
  int n_fail = 0;
  int rdy_low = 0;
  logic stall_q = 1'b0;

  typedef struct {
    int          md;
    logic        fl;
    int          dc;
    int          i1, v1, i2, v2, i3, v3;
    int          stall_idx;
    int          n;
    logic [17:0] tok [8];
    int          rdy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always @(posedge clk) stall_q = stall;

  // Token capture and per-cycle protocol checks
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (DC_valid || valid) begin
        chk("dc_ac_exclusive", {31'd0, DC_valid && valid}, 32'd0);
        if (DC_valid) got_q.push_back({1'b1, last, af_RLC_data_DC});
        else          got_q.push_back({1'b0, last, 4'h0, af_RLC_data_AC});
      end
      if (stall_q)
        chk("stalled_edge_quiet", {29'd0, DC_valid, valid, last}, 32'd0);
      if (!coef_ready && !stall) rdy_low++;
    end
  end

  function automatic logic [7:0] msat(input int v);
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  // Reference: expected token list for the block held in blk
  function automatic void model_block(input int md_in, input logic fl);
    int md, d, run;
    md = (md_in == 3) ? 0 : md_in;
    d = int'(blk[0]) - m_prev[md];
    exp_q.push_back({1'b1, 1'b0, 16'(d)});
    m_prev[md] = int'(blk[0]);
    run = 0;
    for (int i = 1; i < N; i++) begin
      if (blk[i] == 0) begin
        run++;
        if (i == N - 1) exp_q.push_back({1'b0, fl, 16'h0000});
      end else begin
        while (run >= 16) begin
          exp_q.push_back({1'b0, 1'b0, 16'h0F00});
          run -= 16;
        end
        exp_q.push_back({1'b0, (i == N - 1) && fl, 4'h0, 4'(run), msat(int'(blk[i]))});
        run = 0;
      end
    end
    if (fl) for (int k = 0; k < 3; k++) m_prev[k] = 0;
  endfunction

  task automatic feed_block(input int md_in, input logic fl, input int ncoef,
                            input int stall_idx, input bit rs);
    bit accepted;
    int tries;
    for (int i = 0; i < ncoef; i++) begin
      if (i == stall_idx) begin
        repeat (3) begin
          @(negedge clk);
          stall = 1'b1; coef_valid = 1'b1; coef_data = blk[i];
          #1;
          chk("stall_ready_low", {31'd0, coef_ready}, 32'd0);
          @(posedge clk);
          #1;
          chk("stall_no_token", {29'd0, DC_valid, valid, last}, 32'd0);
        end
      end
      accepted = 1'b0;
      tries = 0;
      while (!accepted) begin
        @(negedge clk);
        stall         = rs ? ($urandom_range(0, 4) == 0) : 1'b0;
        coef_valid    = rs ? ($urandom_range(0, 7) != 0) : 1'b1;
        coef_data     = blk[i];
        mode          = 2'(md_in);
        frame_last_in = fl;
        #1;
        accepted = coef_valid && coef_ready;
        @(posedge clk);
        tries++;
        if (!accepted && tries > 100) begin
          chk("accept_timeout", 32'(i), 32'hFFFF_FFFF);
          return;
        end
      end
    end
    @(negedge clk);
    coef_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
    #3;
  endtask

  task automatic check_stream(input string name);
    int n;
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_tok"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N; i++) blk[i] = '0;
    blk[0] = 12'(v.dc);
    if (v.i1 != 0) blk[v.i1] = 12'(v.v1);
    if (v.i2 != 0) blk[v.i2] = 12'(v.v2);
    if (v.i3 != 0) blk[v.i3] = 12'(v.v3);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0,    50, 0,0,0,0,0,0, -1, 2,
               '{18'h20032, 18'h00000, 0,0,0,0,0,0}, 0};
    vecs[1] = '{0, 1'b1,    30, 0,0,0,0,0,0, -1, 2,
               '{18'h2FFEC, 18'h10000, 0,0,0,0,0,0}, 0};
    vecs[2] = '{0, 1'b0,     7, 0,0,0,0,0,0, -1, 2,
               '{18'h20007, 18'h00000, 0,0,0,0,0,0}, 0};
    vecs[3] = '{0, 1'b0,     7, 1,5, 20,-3, 0,0, 21, 5,
               '{18'h20000, 18'h00005, 18'h00F00, 18'h002FD, 18'h00000, 0,0,0}, 1};
    vecs[4] = '{1, 1'b0,  -100, 1,300, 2,-300, 63,1, 30, 7,
               '{18'h2FF9C, 18'h0007F, 18'h00080, 18'h00F00, 18'h00F00, 18'h00F00, 18'h00C01, 0}, 3};
    vecs[5] = '{3, 1'b1,     7, 63,-200, 0,0, 0,0, -1, 5,
               '{18'h20000, 18'h00F00, 18'h00F00, 18'h00F00, 18'h10E80, 0,0,0}, 3};
    vecs[6] = '{1, 1'b0,     5, 0,0,0,0,0,0, -1, 2,
               '{18'h20005, 18'h00000, 0,0,0,0,0,0}, 0};
    vecs[7] = '{2, 1'b0, -2048, 16,2047, 0,0, 0,0, -1, 3,
               '{18'h2F800, 18'h00F7F, 18'h00000, 0,0,0,0,0}, 0};
    vecs[8] = '{2, 1'b0,  2047, 17,-1, 0,0, 0,0, -1, 4,
               '{18'h20FFF, 18'h00F00, 18'h000FF, 18'h00000, 0,0,0,0}, 1};

    for (int k = 0; k < 3; k++) m_prev[k] = 0;
    rst = 1'b1; stall = 1'b0; coef_valid = 1'b0; coef_data = '0;
    mode = '0; frame_last_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_dc_valid", {31'd0, DC_valid}, 32'd0);
    chk("reset_dc_data", {16'd0, af_RLC_data_DC}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ac_data", {20'd0, af_RLC_data_AC}, 32'd0);
    chk("reset_last", {31'd0, last}, 32'd0);
    chk("reset_ready", {31'd0, coef_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      load_vec(vecs[v]);
      model_block(vecs[v].md, vecs[v].fl);
      exp_q.delete();
      rdy_low = 0;
      feed_block(vecs[v].md, vecs[v].fl, N, vecs[v].stall_idx, 1'b0);
      drain();
      chk($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].n));
      for (int t = 0; t < vecs[v].n && t < got_q.size(); t++)
        chk($sformatf("vec%0d_tok%0d", v, t), 32'(got_q[t]), 32'(vecs[v].tok[t]));
      chk($sformatf("vec%0d_ready_low", v), 32'(rdy_low), 32'(vecs[v].rdy));
      got_q.delete();
    end

    // Reset mid-block aborts the block and clears DC history
    for (int i = 0; i < N; i++) blk[i] = '0;
    blk[0] = 12'sd12; blk[5] = 12'sd3;
    feed_block(0, 1'b0, 11, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {29'd0, DC_valid, valid, last}, 32'd0);
    chk("midrst_ac_data", {20'd0, af_RLC_data_AC}, 32'd0);
    chk("midrst_ready", {31'd0, coef_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) m_prev[k] = 0;
    for (int i = 0; i < N; i++) blk[i] = '0;
    blk[0] = 12'sd40;
    model_block(0, 1'b0);
    feed_block(0, 1'b0, N, -1, 1'b0);
    drain();
    if (got_q.size() > 0) chk("postrst_dc", 32'(got_q[0]), 32'h20028);
    else                  chk("postrst_dc", 32'hFFFF_FFFF, 32'h20028);
    check_stream("postrst");

    // Random blocks with random stalls and input bubbles
    for (int b = 0; b < 30; b++) begin
      int md;
      logic fl;
      md = $urandom_range(0, 3);
      fl = ($urandom_range(0, 5) == 0);
      blk[0] = 12'($urandom_range(0, 4095));
      for (int i = 1; i < N; i++) begin
        if ($urandom_range(0, 7) == 0)
          blk[i] = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 4095))
                                                : 12'(int'($urandom_range(0, 20)) - 10);
        else
          blk[i] = '0;
      end
      model_block(md, fl);
      feed_block(md, fl, N, -1, 1'b1);
    end
    drain();
    check_stream("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
